// File: rtl/out_uart.sv
// MIX OUT unit: fetches a block of words from the CPU, unpacks six-bit
// characters, converts them to ASCII and sends them on an 8N1 UART line.
module out_uart #(
  parameter int CLKS_PER_BIT = 104,
  parameter int WORDS        = 14,
  parameter bit EOL          = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] addressin,
  input  logic [29:0] in,
  input  logic        load,
  output logic        request,
  output logic [11:0] addressout,
  output logic        stop,
  output logic        busy,
  output logic        tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int WW = $clog2(WORDS + 1);

  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [WW-1:0] WORD_MAX = WW'(WORDS);
  localparam logic [WW-1:0] WORD_ONE = WW'(1);

  // ASCII for MIX codes 40..55, code 40 in the low byte
  localparam logic [127:0] PUNCT = {
    8'h27, 8'h3A, 8'h3B, 8'h40, 8'h3E, 8'h3C, 8'h24, 8'h3D,
    8'h2F, 8'h2A, 8'h2D, 8'h2B, 8'h29, 8'h28, 8'h2C, 8'h2E
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHARS,
    S_CR,
    S_LF,
    S_DRAIN
  } state_t;

  function automatic logic [7:0] mix_ascii(input logic [5:0] c);
    logic [3:0] k;
    logic [7:0] a;
    k = 4'(c - 6'd40);
    a = 8'h3F;
    unique case (1'b1)
      c == 6'd0:                a = 8'h20;
      c >= 6'd1  && c <= 6'd9:  a = {2'b00, c} + 8'h40;
      c >= 6'd11 && c <= 6'd19: a = {2'b00, c} + 8'h3F;
      c >= 6'd22 && c <= 6'd29: a = {2'b00, c} + 8'h3D;
      c >= 6'd30 && c <= 6'd39: a = {2'b00, c} + 8'h12;
      c >= 6'd40 && c <= 6'd55: a = PUNCT[{k, 3'b000} +: 8];
      default:                  a = 8'h3F;
    endcase
    return a;
  endfunction

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic            request_q, request_d;
  logic            stop_q, stop_d;
  logic [11:0]     addr_q, addr_d;
  logic [11:0]     addr_next_q, addr_next_d;
  logic            pending_q, pending_d;
  logic [29:0]     word_q, word_d;
  logic            have_word_q, have_word_d;
  logic [2:0]      char_idx_q, char_idx_d;
  logic [WW-1:0]   word_cnt_q, word_cnt_d;
  logic            tx_q, tx_d;
  logic            tx_busy_q, tx_busy_d;
  logic [8:0]      shift_q, shift_d;
  logic [3:0]      bit_q, bit_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            frame_end;
  logic            tx_free;
  logic            ld;
  logic [7:0]      ld_byte;
  logic [5:0]      cur_char;

  always_comb begin
    cur_char = word_q[5:0];
    unique case (char_idx_q)
      3'd0:    cur_char = word_q[29:24];
      3'd1:    cur_char = word_q[23:18];
      3'd2:    cur_char = word_q[17:12];
      3'd3:    cur_char = word_q[11:6];
      default: cur_char = word_q[5:0];
    endcase
  end

  // tx_free lets a new frame follow the stop bit with no idle gap
  assign frame_end = tx_busy_q && (bit_q == 4'd9) && (cnt_q == CNT_MAX);
  assign tx_free   = !tx_busy_q || frame_end;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    request_d   = request_q;
    stop_d      = 1'b0;
    addr_d      = addr_q;
    addr_next_d = addr_next_q;
    pending_d   = pending_q;
    word_d      = word_q;
    have_word_d = have_word_q;
    char_idx_d  = char_idx_q;
    word_cnt_d  = word_cnt_q;
    ld          = 1'b0;
    ld_byte     = 8'h00;

    if (request_q && load) begin
      word_d      = in;
      have_word_d = 1'b1;
      char_idx_d  = 3'd0;
      request_d   = 1'b0;
      addr_d      = addr_q + 12'd1;
      word_cnt_d  = word_cnt_q + WORD_ONE;
    end

    if (start) begin
      if (!busy_q) begin
        busy_d      = 1'b1;
        addr_d      = addressin;
        stop_d      = 1'b1;
        request_d   = 1'b1;
        word_cnt_d  = '0;
        char_idx_d  = 3'd0;
        have_word_d = 1'b0;
        state_d     = S_CHARS;
      end else begin
        addr_next_d = addressin;
        pending_d   = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: ;
      S_CHARS: begin
        if (have_word_q && tx_free) begin
          ld      = 1'b1;
          ld_byte = mix_ascii(cur_char);
          if (char_idx_q == 3'd4) begin
            have_word_d = 1'b0;
            if (word_cnt_q < WORD_MAX) request_d = 1'b1;
            else state_d = EOL ? S_CR : S_DRAIN;
          end else begin
            char_idx_d = char_idx_q + 3'd1;
          end
        end
      end
      S_CR: begin
        if (tx_free) begin
          ld      = 1'b1;
          ld_byte = 8'h0D;
          state_d = S_LF;
        end
      end
      S_LF: begin
        if (tx_free) begin
          ld      = 1'b1;
          ld_byte = 8'h0A;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (frame_end) begin
          if (pending_q || start) begin
            addr_d     = start ? addressin : addr_next_q;
            pending_d  = 1'b0;
            stop_d     = 1'b1;
            request_d  = 1'b1;
            word_cnt_d = '0;
            char_idx_d = 3'd0;
            state_d    = S_CHARS;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_d      = tx_q;
    tx_busy_d = tx_busy_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    if (tx_busy_q) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        if (bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
          tx_d      = 1'b1;
        end else begin
          tx_d    = shift_q[0];
          shift_d = {1'b1, shift_q[8:1]};
          bit_d   = bit_q + 4'd1;
        end
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
    if (ld) begin
      tx_busy_d = 1'b1;
      tx_d      = 1'b0;
      shift_d   = {1'b1, ld_byte};
      bit_d     = 4'd0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      request_q   <= 1'b0;
      stop_q      <= 1'b0;
      addr_q      <= '0;
      addr_next_q <= '0;
      pending_q   <= 1'b0;
      word_q      <= '0;
      have_word_q <= 1'b0;
      char_idx_q  <= '0;
      word_cnt_q  <= '0;
      tx_q        <= 1'b1;
      tx_busy_q   <= 1'b0;
      shift_q     <= '1;
      bit_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      request_q   <= request_d;
      stop_q      <= stop_d;
      addr_q      <= addr_d;
      addr_next_q <= addr_next_d;
      pending_q   <= pending_d;
      word_q      <= word_d;
      have_word_q <= have_word_d;
      char_idx_q  <= char_idx_d;
      word_cnt_q  <= word_cnt_d;
      tx_q        <= tx_d;
      tx_busy_q   <= tx_busy_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
    end
  end

  assign request    = request_q;
  assign addressout = addr_q;
  assign stop       = stop_q;
  assign busy       = busy_q;
  assign tx         = tx_q;

endmodule

// File: tb/tb_out_uart.sv
// Bench for out_uart: a UART receiver feeds a scoreboard of expected
// ASCII bytes pushed as words are handed to the unit.
module tb_out_uart;

  localparam int C = 8;
  localparam int W = 14;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] addressin = '0;
  logic [29:0] in_w = '0;
  logic        load = 1'b0;
  logic        request;
  logic [11:0] addressout;
  logic        stop;
  logic        busy;
  logic        tx;

  always #5 clk = ~clk;

  out_uart #(
    .CLKS_PER_BIT(C),
    .WORDS(W),
    .EOL(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .addressin(addressin),
    .in(in_w),
    .load(load),
    .request(request),
    .addressout(addressout),
    .stop(stop),
    .busy(busy),
    .tx(tx)
  );

  int tests = 0;
  int fails = 0;
  byte unsigned sb[$];
  string tbl =
    " ABCDEFGHI?JKLMNOPQR??STUVWXYZ0123456789.,()+-*/=$<>@;:'????????";
  bit mon_en = 1'b1;
  bit hold_busy = 1'b0;
  int stop_cnt = 0;
  int busy_drop = 0;
  int blk_words = 0;
  logic [11:0] exp_addr = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  function automatic logic [29:0] pack5(input int a, input int b,
                                        input int c, input int d,
                                        input int e);
    return 30'(((((a * 64) + b) * 64 + c) * 64 + d) * 64 + e);
  endfunction

  function automatic void push_word(input logic [29:0] w);
    int v;
    v = int'(w);
    for (int k = 4; k >= 0; k--)
      sb.push_back(tbl[(v / (1 << (6 * k))) % 64]);
  endfunction

  always @(posedge clk) begin
    if (stop === 1'b1) stop_cnt <= stop_cnt + 1;
    if (hold_busy && busy !== 1'b1) busy_drop <= busy_drop + 1;
  end

  logic [7:0]   rx_b;
  logic         rx_s0, rx_s9;
  byte unsigned rx_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !reset && tx === 1'b0) begin
        repeat (C / 2) @(negedge clk);
        rx_s0 = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          rx_b[i] = tx;
        end
        repeat (C) @(negedge clk);
        rx_s9 = tx;
        check("rx_start_bit", 32'(rx_s0), 32'd0);
        check("rx_stop_bit", 32'(rx_s9), 32'd1);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rx_extra: got byte 0x%02h, expected none", rx_b);
        end else begin
          rx_exp = sb.pop_front();
          check("rx_byte", 32'(rx_b), 32'(rx_exp));
        end
      end
    end
  end

  task automatic serve_word(input logic [29:0] w, input int dly,
                            input bit spur, input int exp_stop);
    int n;
    int bad;
    n = 0;
    bad = 0;
    while (request !== 1'b1 && n < 200 * C) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", 32'(request), 32'd1);
    check("req_addr", 32'(addressout), 32'(exp_addr));
    if (exp_stop >= 0) check("stop_with_req", 32'(stop), 32'(exp_stop));
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (request !== 1'b1 || addressout !== exp_addr) bad++;
    end
    if (dly > 0) check("req_held", 32'(bad), 32'd0);
    in_w = w;
    load = 1'b1;
    push_word(w);
    blk_words++;
    if (blk_words == W) begin
      sb.push_back(8'h0D);
      sb.push_back(8'h0A);
      blk_words = 0;
    end
    @(negedge clk);
    exp_addr = exp_addr + 12'd1;
    check("addr_inc", 32'(addressout), 32'(exp_addr));
    check("req_drop", 32'(request), 32'd0);
    if (spur) begin
      in_w = 30'($urandom);
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 2000 * C) begin
      @(negedge clk);
      n++;
    end
    check("busy_fall", 32'(busy), 32'd0);
  endtask

  task automatic pulse_start(input logic [11:0] a);
    addressin = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] w;
    int cyc;
    int bad;
    time t0;

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_request", 32'(request), 32'd0);
    check("rst_stop", 32'(stop), 32'd0);
    check("rst_addr", 32'(addressout), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_tx", 32'(tx), 32'd1);

    // Block from 100: HELLO, unmapped codes, digits, random
    exp_addr = 12'd100;
    t0 = $time;
    pulse_start(12'd100);
    check("a_busy", 32'(busy), 32'd1);
    for (int i = 0; i < W; i++) begin
      if (i == 0) w = pack5(8, 5, 13, 13, 16);
      else if (i == 1) w = pack5(10, 20, 21, 56, 63);
      else if (i < 8) w = pack5(30, 31, 32, 33, 34);
      else w = 30'($urandom);
      serve_word(w, 0, 1'b0, (i == 0) ? 1 : -1);
      if (i == 0) check("a_stop_one_cycle", 32'(stop), 32'd0);
    end
    wait_idle();
    cyc = int'(($time - t0) / 10);
    check("a_block_cycles_ok",
          32'((cyc >= 720 * C) && (cyc <= 720 * C + 8)), 32'd1);
    check("a_addr_end", 32'(addressout), 32'd114);
    check("a_sb_empty", 32'(sb.size()), 32'd0);
    check("a_stop_count", 32'(stop_cnt), 32'd1);

    // Block from 200 with queued starts (latest wins: 4090)
    exp_addr = 12'd200;
    pulse_start(12'd200);
    hold_busy = 1'b1;
    for (int i = 0; i < W; i++) begin
      serve_word(30'($urandom), int'($urandom_range(0, 4)), 1'b1,
                 (i == 0) ? 1 : -1);
      if (i == 4) pulse_start(12'd777);
      if (i == 8) pulse_start(12'd4090);
    end
    check("b_no_early_stop", 32'(stop_cnt), 32'd2);

    // Queued block from 4090 with wrap and a long-held request
    exp_addr = 12'd4090;
    for (int i = 0; i < W; i++) begin
      serve_word(30'($urandom),
                 (i == 3) ? 50 : int'($urandom_range(0, 3)), 1'b0,
                 (i == 0) ? 1 : -1);
      if (i == 0) check("c_queued_stop_cnt", 32'(stop_cnt), 32'd3);
    end
    hold_busy = 1'b0;
    check("c_busy_held", 32'(busy_drop), 32'd0);
    wait_idle();
    check("c_addr_wrap", 32'(addressout), 32'd8);
    check("c_sb_empty", 32'(sb.size()), 32'd0);
    check("c_stop_count", 32'(stop_cnt), 32'd3);

    // Reset in the middle of a frame, with a start queued
    mon_en = 1'b0;
    repeat (4) @(negedge clk);
    exp_addr = 12'd50;
    pulse_start(12'd50);
    serve_word(pack5(0, 1, 2, 3, 4), 0, 1'b0, -1);
    pulse_start(12'd60);
    repeat (3 * C) @(negedge clk);
    check("d_tx_midframe", 32'(tx), 32'd0);
    check("d_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("d_rst_tx", 32'(tx), 32'd1);
    check("d_rst_busy", 32'(busy), 32'd0);
    check("d_rst_request", 32'(request), 32'd0);
    check("d_rst_stop", 32'(stop), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || stop !== 1'b0 ||
          request !== 1'b0) bad++;
    end
    check("d_idle_after_reset", 32'(bad), 32'd0);
    check("d_stop_count", 32'(stop_cnt), 32'd4);
    sb.delete();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
